// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle carried from the timing generator to the pixel
// drawing modules. The generator drives it through the master modport;
// every sprite/ROM consumer reads it through the slave modport.
interface vga_timing_gen_if;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        output hs,
        output vs,
        output blank,
        output DrawX,
        output DrawY,
        output frame_start,
        output frame_count
    );

    modport slave (
        input hs,
        input vs,
        input blank,
        input DrawX,
        input DrawY,
        input frame_start,
        input frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing source.
// Two free-running counters (hc, vc) walk the raster. Every output is a
// register loaded from the pre-edge counter values, so all of them
// describe the same pixel and trail the counters by exactly one cycle.

// Structural checks for the timing generator: raster size limits at
// elaboration, and frame_start only ever marking the raster origin.
module vga_timing_gen_chk #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input logic       vga_clk,
    input logic       reset_n,
    input logic       frame_start,
    input logic [9:0] draw_x,
    input logic [9:0] draw_y
);
    if ((H_TOTAL < 1) || (H_TOTAL > 1024)) begin : g_h_total_bad
        $error("vga_timing_gen: H_TOTAL must lie in 1..1024");
    end

    if ((V_TOTAL < 1) || (V_TOTAL > 1024)) begin : g_v_total_bad
        $error("vga_timing_gen: V_TOTAL must lie in 1..1024");
    end

    a_frame_start_at_origin: assert property (
        @(posedge vga_clk) disable iff (!reset_n)
        frame_start |-> ((draw_x == 10'd0) && (draw_y == 10'd0))
    ) else $error("vga_timing_gen: frame_start away from (0,0)");
endmodule

module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input logic              vga_clk,
    input logic              reset_n,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last counter values before wrapping.
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Decode boundaries are 11 bits wide so a sync end of 1024 still fits.
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Raster position counters.
    logic [9:0]  hc_r;
    logic [9:0]  vc_r;
    logic [9:0]  hc_nxt_s;
    logic [9:0]  vc_nxt_s;
    logic        hc_end_s;
    logic        vc_end_s;

    // Decoded values for the pixel currently addressed by (hc, vc).
    logic [10:0] hc_ext_s;
    logic [10:0] vc_ext_s;
    logic        hs_nxt_s;
    logic        vs_nxt_s;
    logic        blank_nxt_s;
    logic        frame_start_nxt_s;
    logic [15:0] frame_count_nxt_s;

    // Output registers.
    logic        hs_r;
    logic        vs_r;
    logic        blank_r;
    logic [9:0]  draw_x_r;
    logic [9:0]  draw_y_r;
    logic        frame_start_r;
    logic [15:0] frame_count_r;

    // Next counter values: hc wraps at line end, vc steps only on that wrap.
    always_comb begin
        hc_end_s = 1'b0;
        vc_end_s = 1'b0;
        hc_nxt_s = hc_r;
        vc_nxt_s = vc_r;
        if (hc_r == H_LAST) begin
            hc_end_s = 1'b1;
        end else begin
            hc_end_s = 1'b0;
        end
        if (vc_r == V_LAST) begin
            vc_end_s = 1'b1;
        end else begin
            vc_end_s = 1'b0;
        end
        if (hc_end_s) begin
            hc_nxt_s = 10'd0;
            if (vc_end_s) begin
                vc_nxt_s = 10'd0;
            end else begin
                vc_nxt_s = vc_r + 10'd1;
            end
        end else begin
            hc_nxt_s = hc_r + 10'd1;
            vc_nxt_s = vc_r;
        end
    end

    // Decode sync, active-video and frame strobe for the pre-edge position.
    always_comb begin
        hc_ext_s          = {1'b0, hc_r};
        vc_ext_s          = {1'b0, vc_r};
        hs_nxt_s          = 1'b1;
        vs_nxt_s          = 1'b1;
        blank_nxt_s       = 1'b0;
        frame_start_nxt_s = 1'b0;
        frame_count_nxt_s = frame_count_r;
        if ((hc_ext_s >= HS_START) && (hc_ext_s < HS_END)) begin
            hs_nxt_s = 1'b0;
        end else begin
            hs_nxt_s = 1'b1;
        end
        // Vertical sync depends only on the line, so it stays low for whole lines.
        if ((vc_ext_s >= VS_START) && (vc_ext_s < VS_END)) begin
            vs_nxt_s = 1'b0;
        end else begin
            vs_nxt_s = 1'b1;
        end
        if ((hc_ext_s < H_ACT_END) && (vc_ext_s < V_ACT_END)) begin
            blank_nxt_s = 1'b1;
        end else begin
            blank_nxt_s = 1'b0;
        end
        // The frame counter advances together with the strobe; 16-bit wrap is natural.
        if ((hc_r == 10'd0) && (vc_r == 10'd0)) begin
            frame_start_nxt_s = 1'b1;
            frame_count_nxt_s = frame_count_r + 16'd1;
        end else begin
            frame_start_nxt_s = 1'b0;
            frame_count_nxt_s = frame_count_r;
        end
    end

    // Raster counter state; reset returns the raster to its origin at once.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_r <= 10'd0;
            vc_r <= 10'd0;
        end else begin
            hc_r <= hc_nxt_s;
            vc_r <= vc_nxt_s;
        end
    end

    // Output registers, loaded from the same pre-edge position as one pixel.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            blank_r       <= 1'b0;
            draw_x_r      <= 10'd0;
            draw_y_r      <= 10'd0;
            frame_start_r <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            hs_r          <= hs_nxt_s;
            vs_r          <= vs_nxt_s;
            blank_r       <= blank_nxt_s;
            draw_x_r      <= hc_r;
            draw_y_r      <= vc_r;
            frame_start_r <= frame_start_nxt_s;
            frame_count_r <= frame_count_nxt_s;
        end
    end

    assign vga.hs          = hs_r;
    assign vga.vs          = vs_r;
    assign vga.blank       = blank_r;
    assign vga.DrawX       = draw_x_r;
    assign vga.DrawY       = draw_y_r;
    assign vga.frame_start = frame_start_r;
    assign vga.frame_count = frame_count_r;

    vga_timing_gen_chk #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_chk (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_start (frame_start_r),
        .draw_x      (draw_x_r),
        .draw_y      (draw_y_r)
    );
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Three instances share one clock:
//   def  - default 800x525 raster (line timing, mid-line asynchronous reset)
//   sm   - 8x6 raster (whole frames, vsync, frame spacing)
//   ti   - 1x1 raster, one frame per clock (frame_count 16-bit wrap)
// The reference model maps "edges since reset release" straight to a raster
// position with division/modulo and applies the decode rules to it.
module tb_vga_timing_gen;
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    localparam obs_t RST_OBS = '{hs:1'b1, vs:1'b1, blank:1'b0, x:10'd0, y:10'd0, fs:1'b0, fc:16'd0};
    localparam obs_t FIRST_OBS = '{hs:1'b1, vs:1'b1, blank:1'b1, x:10'd0, y:10'd0, fs:1'b1, fc:16'd1};

    logic vga_clk = 1'b0;
    logic rst_def_n = 1'b0;
    logic rst_sm_n  = 1'b0;
    logic rst_ti_n  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Edges seen by each instance since its reset was last released.
    int k_def = 0;
    int k_sm  = 0;
    int k_ti  = 0;

    int def_hs_low  = 0;
    int def_blank_hi = 0;
    int sm_last_fs  = -1;
    int sm_vs_low   = 0;
    int sm_fs_seen  = 0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen_if if_def ();
    vga_timing_gen_if if_sm ();
    vga_timing_gen_if if_ti ();

    vga_timing_gen u_def (
        .vga_clk (vga_clk),
        .reset_n (rst_def_n),
        .vga     (if_def.master)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) u_sm (
        .vga_clk (vga_clk),
        .reset_n (rst_sm_n),
        .vga     (if_sm.master)
    );

    vga_timing_gen #(
        .H_ACTIVE (1), .H_FP (0), .H_SYNC (0), .H_BP (0),
        .V_ACTIVE (1), .V_FP (0), .V_SYNC (0), .V_BP (0)
    ) u_ti (
        .vga_clk (vga_clk),
        .reset_n (rst_ti_n),
        .vga     (if_ti.master)
    );

    obs_t a_def, a_sm, a_ti;
    assign a_def = {if_def.hs, if_def.vs, if_def.blank, if_def.DrawX, if_def.DrawY, if_def.frame_start, if_def.frame_count};
    assign a_sm  = {if_sm.hs,  if_sm.vs,  if_sm.blank,  if_sm.DrawX,  if_sm.DrawY,  if_sm.frame_start,  if_sm.frame_count};
    assign a_ti  = {if_ti.hs,  if_ti.vs,  if_ti.blank,  if_ti.DrawX,  if_ti.DrawY,  if_ti.frame_start,  if_ti.frame_count};

    // Expected outputs after k edges since reset release.
    function automatic obs_t model(input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input int k);
        obs_t o;
        int ht, vt, p, x, y;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (k == 0) begin
            o = RST_OBS;
        end else begin
            p = (k - 1) % (ht * vt);
            x = p % ht;
            y = p / ht;
            o.x     = 10'(x);
            o.y     = 10'(y);
            o.hs    = !((x >= ha + hf) && (x < ha + hf + hsw));
            o.vs    = !((y >= va + vf) && (y < va + vf + vsw));
            o.blank = (x < ha) && (y < va);
            o.fs    = (p == 0);
            o.fc    = 16'((((k - 1) / (ht * vt)) + 1) % 65536);
        end
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t: got hs=%b vs=%b blank=%b x=%0d y=%0d fs=%b fc=%h, want hs=%b vs=%b blank=%b x=%0d y=%0d fs=%b fc=%h",
                     name, $time, act.hs, act.vs, act.blank, act.x, act.y, act.fs, act.fc,
                     exp.hs, exp.vs, exp.blank, exp.x, exp.y, exp.fs, exp.fc);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Edge counters per instance, cleared asynchronously with that instance's reset.
    always @(posedge vga_clk or negedge rst_def_n) begin
        if (!rst_def_n) k_def <= 0;
        else            k_def <= k_def + 1;
    end

    always @(posedge vga_clk or negedge rst_sm_n) begin
        if (!rst_sm_n) k_sm <= 0;
        else           k_sm <= k_sm + 1;
    end

    always @(posedge vga_clk or negedge rst_ti_n) begin
        if (!rst_ti_n) k_ti <= 0;
        else           k_ti <= k_ti + 1;
    end

    // Compare every instance against the model on each falling edge,
    // plus hand-computed pins at chosen raster positions.
    always @(negedge vga_clk) begin
        check_obs("def_model", a_def, model(640, 16, 96, 48, 480, 10, 2, 33, k_def));
        check_obs("sm_model",  a_sm,  model(4, 1, 2, 1, 3, 1, 1, 1, k_sm));
        check_obs("ti_model",  a_ti,  model(1, 0, 0, 0, 1, 0, 0, 0, k_ti));

        // Default raster: first line.
        if (k_def == 0) begin
            def_hs_low   = 0;
            def_blank_hi = 0;
        end else if (k_def <= 800) begin
            if (!a_def.hs)   def_hs_low++;
            if (a_def.blank) def_blank_hi++;
        end
        if (k_def == 1)   check_obs("def_first_edge", a_def, FIRST_OBS);
        if (k_def == 640) begin
            check_val("def_x639", int'(a_def.x), 639);
            check_val("def_blank_x639", int'(a_def.blank), 1);
        end
        if (k_def == 641) check_val("def_blank_x640", int'(a_def.blank), 0);
        if (k_def == 656) check_val("def_hs_x655", int'(a_def.hs), 1);
        if (k_def == 657) begin
            check_val("def_x656", int'(a_def.x), 656);
            check_val("def_hs_x656", int'(a_def.hs), 0);
        end
        if (k_def == 752) check_val("def_hs_x751", int'(a_def.hs), 0);
        if (k_def == 753) check_val("def_hs_x752", int'(a_def.hs), 1);
        if (k_def == 800) begin
            check_val("def_x799", int'(a_def.x), 799);
            check_val("def_hs_low_per_line", def_hs_low, 96);
            check_val("def_blank_per_line", def_blank_hi, 640);
        end
        if (k_def == 801) begin
            check_val("def_wrap_x", int'(a_def.x), 0);
            check_val("def_wrap_y", int'(a_def.y), 1);
            check_val("def_wrap_fs", int'(a_def.fs), 0);
        end

        // Small raster: sync positions and frame spacing.
        if (k_sm == 6) begin
            check_val("sm_x5", int'(a_sm.x), 5);
            check_val("sm_hs_x5", int'(a_sm.hs), 0);
        end
        if (k_sm == 8) check_val("sm_hs_x7", int'(a_sm.hs), 1);
        if (k_sm == 33) begin
            check_val("sm_y4", int'(a_sm.y), 4);
            check_val("sm_vs_y4", int'(a_sm.vs), 0);
        end
        if (k_sm == 49) begin
            check_val("sm_second_fs", int'(a_sm.fs), 1);
            check_val("sm_second_fc", int'(a_sm.fc), 2);
        end
        if (k_sm == 0) begin
            sm_last_fs = -1;
            sm_vs_low  = 0;
            sm_fs_seen = 0;
        end else begin
            if (a_sm.fs) begin
                sm_fs_seen++;
                if (sm_last_fs > 0) begin
                    check_val("sm_fs_spacing", k_sm - sm_last_fs, 48);
                    check_val("sm_vs_low_per_frame", sm_vs_low, 8);
                end
                sm_last_fs = k_sm;
                sm_vs_low  = 0;
            end
            if (!a_sm.vs) sm_vs_low++;
        end

        // One-pixel raster: frame counter wrap.
        if (k_ti == 65535) begin
            check_val("ti_fc_ffff", int'(a_ti.fc), 65535);
            check_val("ti_fs_ffff", int'(a_ti.fs), 1);
        end
        if (k_ti == 65536) begin
            check_val("ti_fc_wrap", int'(a_ti.fc), 0);
            check_val("ti_fs_wrap", int'(a_ti.fs), 1);
        end
        if (k_ti == 65537) check_val("ti_fc_after_wrap", int'(a_ti.fc), 1);
    end

    initial begin
        repeat (3) @(posedge vga_clk);
        #2;
        rst_def_n = 1'b1;
        rst_sm_n  = 1'b1;
        rst_ti_n  = 1'b1;

        // Run the default raster to DrawX=300, DrawY=1, then reset between edges.
        repeat (1101) @(posedge vga_clk);
        #2;
        rst_def_n = 1'b0;
        #1;
        check_obs("def_async_reset", a_def, RST_OBS);
        repeat (2) @(posedge vga_clk);
        #2;
        rst_def_n = 1'b1;

        // The one-pixel raster needs 65536 frames; everything else runs alongside.
        while (k_ti < 65540) @(posedge vga_clk);
        @(negedge vga_clk);
        #1;
        check_val("sm_fs_count", sm_fs_seen, ((k_sm - 1) / 48) + 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
